preproc_frame_ctrl: RTL and testbench

Frame-level sequencer for the camera-link image preprocessing pipeline (interface convert → decimate → difference → packet). It decides per frame whether the frame is captured as a new reference into the difference BRAM or differenced against the stored reference. It gates upstream stream acceptance and counts completed frames. It stops the pipeline on any error flag and holds it stopped until software restarts a run.

---
 rtl/preproc_frame_ctrl_if.sv | 41 ++++
 rtl/preproc_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_preproc_frame_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/preproc_frame_ctrl_if.sv
// Control/status bundle of the frame sequencer.
//   start, stop, num_frames     : run control from software
//   frame_start_i, frame_store_i: frame events from the pipeline
//   fifo_overflow_i, unexpected_data_i, unexpected_tlast_i : error indications
//   stream_en_o, frame_type_o, diff_en_o, busy_o, done_o,
//   frame_cnt_o, err_o           : sequencer status/controls
// Modports: master drives the inputs (software/pipeline side),
//           slave is the sequencer itself.
interface preproc_frame_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] num_frames;
  logic             frame_start_i;
  logic             frame_store_i;
  logic             fifo_overflow_i;
  logic             unexpected_data_i;
  logic             unexpected_tlast_i;
  logic             stream_en_o;
  logic [1:0]       frame_type_o;
  logic             diff_en_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] frame_cnt_o;
  logic [3:0]       err_o;

  modport master (
    output start, stop, num_frames, frame_start_i, frame_store_i,
           fifo_overflow_i, unexpected_data_i, unexpected_tlast_i,
    input  stream_en_o, frame_type_o, diff_en_o, busy_o, done_o,
           frame_cnt_o, err_o
  );

  modport slave (
    input  start, stop, num_frames, frame_start_i, frame_store_i,
           fifo_overflow_i, unexpected_data_i, unexpected_tlast_i,
    output stream_en_o, frame_type_o, diff_en_o, busy_o, done_o,
           frame_cnt_o, err_o
  );
endinterface

// File: rtl/preproc_frame_ctrl.sv
// Frame-level sequencer for the preprocessing pipeline. Chooses per frame
// whether it is captured as a new reference (REF) or differenced (DIFF),
// gates upstream acceptance, counts completed frames and latches errors.
// Ports:
//   aclk    : clock, rising edge
//   aresetn : asynchronous active-low reset
//   bus     : preproc_frame_ctrl_if.slave control/status bundle
module preproc_frame_ctrl #(
  parameter int unsigned REF_PERIOD = 16,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 aclk,
  input logic                 aresetn,
  preproc_frame_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] T_REF  = 2'b00;
  localparam logic [1:0] T_DIFF = 2'b01;

  localparam logic [15:0] REF_LAST = 16'(REF_PERIOD - 1);

  logic [1:0]       state_q, state_d;
  logic [15:0]      ref_cnt_q, ref_cnt_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       err_q, err_d;
  logic [1:0]       type_q, type_d;
  logic             done_q, done_d;
  logic             stream_en_q;
  logic             diff_en_q;

  logic [3:0]       err_hit;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    state_d     = state_q;
    ref_cnt_d   = ref_cnt_q;
    stop_pend_d = stop_pend_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    type_d      = type_q;
    done_d      = 1'b0;
    err_hit     = '0;
    cnt_inc     = cnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_ERR: begin
        // A restart always begins with REF: BRAM contents are untrusted.
        if (bus.start) begin
          state_d     = S_ARM;
          ref_cnt_d   = '0;
          stop_pend_d = 1'b0;
          num_d       = bus.num_frames;
          cnt_d       = '0;
          err_d       = '0;
          type_d      = T_REF;
        end
      end
      S_ARM: begin
        err_hit = {1'b0, bus.unexpected_tlast_i, bus.unexpected_data_i,
                   bus.fifo_overflow_i};
        if (|err_hit) begin
          err_d   = err_q | err_hit;
          state_d = S_ERR;
        end else if (bus.stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (bus.frame_start_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A second frame start without a store is a sequence error (bit 3);
        // all errors outrank store/stop so the faulty frame is not counted.
        err_hit = {bus.frame_start_i, bus.unexpected_tlast_i,
                   bus.unexpected_data_i, bus.fifo_overflow_i};
        if (|err_hit) begin
          err_d   = err_q | err_hit;
          state_d = S_ERR;
        end else if (bus.frame_store_i) begin
          cnt_d = cnt_inc;
          if (stop_pend_q || bus.stop || ((num_q != '0) && (cnt_inc == num_q))) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ARM;
            if (ref_cnt_q >= REF_LAST) begin
              ref_cnt_d = '0;
              type_d    = T_REF;
            end else begin
              ref_cnt_d = ref_cnt_q + 16'd1;
              type_d    = T_DIFF;
            end
          end
        end else if (bus.stop) begin
          stop_pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      ref_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      num_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      type_q      <= T_REF;
      done_q      <= 1'b0;
      stream_en_q <= 1'b0;
      diff_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_cnt_q   <= ref_cnt_d;
      stop_pend_q <= stop_pend_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      type_q      <= type_d;
      done_q      <= done_d;
      stream_en_q <= (state_d == S_ARM) || (state_d == S_RUN);
      diff_en_q   <= (type_d == T_DIFF);
    end
  end

  assign bus.stream_en_o  = stream_en_q;
  assign bus.busy_o       = stream_en_q;
  assign bus.frame_type_o = type_q;
  assign bus.diff_en_o    = diff_en_q;
  assign bus.done_o       = done_q;
  assign bus.frame_cnt_o  = cnt_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_preproc_frame_ctrl.sv
module tb_preproc_frame_ctrl;

  logic aclk = 1'b0;
  logic aresetn;

  always #5 aclk = ~aclk;

  preproc_frame_ctrl_if #(.CNT_W(16)) ia ();
  preproc_frame_ctrl_if #(.CNT_W(4))  ib ();

  preproc_frame_ctrl #(.REF_PERIOD(4), .CNT_W(16)) u_dut_a (
    .aclk(aclk), .aresetn(aresetn), .bus(ia.slave)
  );

  preproc_frame_ctrl #(.REF_PERIOD(1), .CNT_W(4)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .bus(ib.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic a_start(input logic [15:0] nf);
    ia.num_frames = nf;
    ia.start = 1'b1; tick(); ia.start = 1'b0;
  endtask
  task automatic a_fstart();
    ia.frame_start_i = 1'b1; tick(); ia.frame_start_i = 1'b0;
  endtask
  task automatic a_fstore();
    ia.frame_store_i = 1'b1; tick(); ia.frame_store_i = 1'b0;
  endtask
  task automatic a_stop();
    ia.stop = 1'b1; tick(); ia.stop = 1'b0;
  endtask

  task automatic a_reset_vals(input string tag);
    check({tag, "_sen"},  32'(ia.stream_en_o),  32'd0);
    check({tag, "_type"}, 32'(ia.frame_type_o), 32'd0);
    check({tag, "_diff"}, 32'(ia.diff_en_o),    32'd0);
    check({tag, "_busy"}, 32'(ia.busy_o),       32'd0);
    check({tag, "_done"}, 32'(ia.done_o),       32'd0);
    check({tag, "_cnt"},  32'(ia.frame_cnt_o),  32'd0);
    check({tag, "_err"},  32'(ia.err_o),        32'd0);
  endtask

  initial begin
    ia.start = 0; ia.stop = 0; ia.num_frames = '0; ia.frame_start_i = 0;
    ia.frame_store_i = 0; ia.fifo_overflow_i = 0; ia.unexpected_data_i = 0;
    ia.unexpected_tlast_i = 0;
    ib.start = 0; ib.stop = 0; ib.num_frames = '0; ib.frame_start_i = 0;
    ib.frame_store_i = 0; ib.fifo_overflow_i = 0; ib.unexpected_data_i = 0;
    ib.unexpected_tlast_i = 0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    tick();
    a_reset_vals("rst");

    // REF_PERIOD=4, six frames: REF,DIFF,DIFF,DIFF,REF,DIFF then done
    a_start(16'd6);
    check("t1_busy", 32'(ia.busy_o), 32'd1);
    check("t1_sen",  32'(ia.stream_en_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_type%0d", i), 32'(ia.frame_type_o), (i % 4 == 0) ? 32'd0 : 32'd1);
      check($sformatf("t1_diff%0d", i), 32'(ia.diff_en_o),    (i % 4 == 0) ? 32'd0 : 32'd1);
      a_fstart();
      check($sformatf("t1_run%0d", i), 32'(ia.busy_o), 32'd1);
      a_fstore();
      check($sformatf("t1_cnt%0d", i), 32'(ia.frame_cnt_o), 32'(i + 1));
      check($sformatf("t1_done%0d", i), 32'(ia.done_o), (i == 5) ? 32'd1 : 32'd0);
    end
    check("t1_idle", 32'(ia.busy_o), 32'd0);
    check("t1_sen_off", 32'(ia.stream_en_o), 32'd0);
    tick();
    check("t1_done_pulse", 32'(ia.done_o), 32'd0);
    check("t1_cnt_hold", 32'(ia.frame_cnt_o), 32'd6);

    // stop during RUN of frame 3
    a_start(16'd0);
    check("t3_cnt_clr", 32'(ia.frame_cnt_o), 32'd0);
    repeat (2) begin a_fstart(); a_fstore(); end
    a_fstart();
    a_stop();
    check("t3_still_run", 32'(ia.busy_o), 32'd1);
    check("t3_no_done", 32'(ia.done_o), 32'd0);
    a_fstore();
    check("t3_cnt", 32'(ia.frame_cnt_o), 32'd3);
    check("t3_done", 32'(ia.done_o), 32'd1);
    check("t3_idle", 32'(ia.busy_o), 32'd0);

    // stop while ARMed
    a_start(16'd0);
    a_fstart(); a_fstore();
    a_stop();
    check("t3b_done", 32'(ia.done_o), 32'd1);
    check("t3b_idle", 32'(ia.busy_o), 32'd0);
    check("t3b_cnt",  32'(ia.frame_cnt_o), 32'd1);

    // overflow coincident with store of frame 2
    a_start(16'd0);
    a_fstart(); a_fstore();
    check("t4_type_diff", 32'(ia.frame_type_o), 32'd1);
    a_fstart();
    ia.fifo_overflow_i = 1'b1; ia.frame_store_i = 1'b1; tick();
    ia.fifo_overflow_i = 1'b0; ia.frame_store_i = 1'b0;
    check("t4_err", 32'(ia.err_o), 32'b0001);
    check("t4_sen", 32'(ia.stream_en_o), 32'd0);
    check("t4_busy", 32'(ia.busy_o), 32'd0);
    check("t4_cnt", 32'(ia.frame_cnt_o), 32'd1);
    ia.unexpected_data_i = 1'b1; tick(); ia.unexpected_data_i = 1'b0;
    tick();
    check("t4_err_hold", 32'(ia.err_o), 32'b0001);
    a_start(16'd0);
    check("t4_rs_busy", 32'(ia.busy_o), 32'd1);
    check("t4_rs_type", 32'(ia.frame_type_o), 32'd0);
    check("t4_rs_diff", 32'(ia.diff_en_o), 32'd0);
    check("t4_rs_err",  32'(ia.err_o), 32'd0);
    check("t4_rs_cnt",  32'(ia.frame_cnt_o), 32'd0);

    // two frame starts without a store
    a_fstart();
    a_fstart();
    check("t5_err", 32'(ia.err_o), 32'b1000);
    check("t5_sen", 32'(ia.stream_en_o), 32'd0);

    // reset mid-RUN
    a_start(16'd0);
    a_fstart(); a_fstore();
    check("t6_cnt", 32'(ia.frame_cnt_o), 32'd1);
    a_fstart();
    #2 aresetn = 1'b0;
    #1 a_reset_vals("t6_rst");
    @(negedge aclk) aresetn = 1'b1;
    tick();
    a_start(16'd2);
    check("t6_type0", 32'(ia.frame_type_o), 32'd0);
    a_fstart(); a_fstore();
    check("t6_type1", 32'(ia.frame_type_o), 32'd1);
    check("t6_nodone", 32'(ia.done_o), 32'd0);
    a_fstart(); a_fstore();
    check("t6_cnt2", 32'(ia.frame_cnt_o), 32'd2);
    check("t6_done", 32'(ia.done_o), 32'd1);

    // REF_PERIOD=1, CNT_W=4, continuous, 17 frames: all REF, count wraps
    ib.num_frames = '0;
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("b_type%0d", i), 32'(ib.frame_type_o), 32'd0);
      ib.frame_start_i = 1'b1; tick(); ib.frame_start_i = 1'b0;
      ib.frame_store_i = 1'b1; tick(); ib.frame_store_i = 1'b0;
      check($sformatf("b_cnt%0d", i), 32'(ib.frame_cnt_o), 32'((i + 1) % 16));
      check($sformatf("b_done%0d", i), 32'(ib.done_o), 32'd0);
    end
    check("b_busy", 32'(ib.busy_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
